// File: rtl/hilo_pkg.sv
// Shared op codes, FSM states and helpers for the HI/LO multiply sequencer.
package hilo_pkg;

    localparam int unsigned MUL_CYCLES = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_MADDU = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Unsigned magnitude; 0x8000_0000 maps to itself, which is 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_shift_mul.sv
// 32x32 shift-add multiplier datapath: product register, 33-bit adder and final negation.
module hilo_shift_mul (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic        negate,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic [31:0] a_q;
    logic [63:0] p;
    logic [32:0] sum;

    always_comb sum = {1'b0, p[63:32]} + {1'b0, a_q};

    // Carry of the upper-half add becomes the new MSB as the product shifts right.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            p   <= '0;
        end else if (load) begin
            a_q <= a;
            p   <= {32'b0, b};
        end else if (step) begin
            p <= p[0] ? {sum, p[31:1]} : {1'b0, p[63:1]};
        end
    end

    assign result = negate ? (~p + 64'd1) : p;

endmodule

// File: rtl/hilo_mul_ctrl.sv
// Multi-cycle MULTU/MULT/MADDU sequencer driving the HI/LO write port and EX stall.
// Define HILO_MADD_EN to make MADDU accumulate into HI/LO; otherwise MADDU acts as MULTU.
module hilo_mul_ctrl #(
    parameter int unsigned MUL_CYCLES = hilo_pkg::MUL_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mfhl_req,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [63:0] MultuAns,
    output logic        HL
);

    import hilo_pkg::state_t;
    import hilo_pkg::ST_IDLE;
    import hilo_pkg::ST_RUN;
    import hilo_pkg::ST_WRITE;
    import hilo_pkg::OP_MULT;
    import hilo_pkg::OP_MADDU;
    import hilo_pkg::OP_RSVD;
    import hilo_pkg::mag32;

    localparam logic [5:0] LAST_STEP = 6'(MUL_CYCLES - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        accept;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] result;
`ifdef HILO_MADD_EN
    logic        madd_q;
`endif

    assign accept = (state == ST_IDLE) && start && (op != OP_RSVD);
    assign a_in   = (op == OP_MULT) ? mag32(src_a) : src_a;
    assign b_in   = (op == OP_MULT) ? mag32(src_b) : src_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            neg_q  <= 1'b0;
            done   <= 1'b0;
            HL     <= 1'b1;
`ifdef HILO_MADD_EN
            madd_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    HL   <= 1'b1;
                    if (accept) begin
                        state  <= ST_RUN;
                        cnt    <= '0;
                        neg_q  <= (op == OP_MULT) && (src_a[31] ^ src_b[31]);
`ifdef HILO_MADD_EN
                        madd_q <= (op == OP_MADDU);
`endif
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= ST_WRITE;
                        done  <= 1'b1;
`ifdef HILO_MADD_EN
                        HL    <= madd_q;
`else
                        HL    <= 1'b0;
`endif
                    end
                end
                ST_WRITE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    HL    <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    HL    <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign stall    = (mfhl_req | start) & busy;
    // done is high exactly in WRITE, so HI/LO sees zero with HL=1 at all other times.
    assign MultuAns = done ? result : '0;

    hilo_shift_mul u_mul (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .step   (state == ST_RUN),
        .negate (neg_q),
        .a      (a_in),
        .b      (b_in),
        .result (result)
    );

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Self-checking bench for hilo_mul_ctrl; models the HI/LO register and products arithmetically.
module tb_hilo_mul_ctrl;

`ifdef HILO_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mfhl_req = 1'b0;
    logic        busy, stall, done, HL;
    logic [63:0] MultuAns;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hilo_mul_ctrl #(.MUL_CYCLES(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mfhl_req (mfhl_req),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .MultuAns (MultuAns),
        .HL       (HL)
    );

    // HI/LO register: captures on the falling edge, load or accumulate.
    logic [63:0] hilo = '0;
    logic        preload = 1'b0;
    logic [63:0] preload_val = '0;
    always @(negedge clk) begin
        if (preload)  hilo <= preload_val;
        else if (!HL) hilo <= MultuAns;
        else          hilo <= hilo + MultuAns;
    end

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] ans;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (o == 2'b01) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Waits for the WRITE cycle (bounded), counting cycles with busy high.
    task automatic wait_done(output logic [63:0] ans, output logic hl_o, output int cyc, output bit ok);
        ans = '0; hl_o = 1'b0; cyc = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (busy) cyc++;
            if (done) begin
                ans = MultuAns;
                hl_o = HL;
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_mul(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_ans, input logic exp_hl, input logic [63:0] exp_hilo);
        logic [63:0] ans;
        logic        hl_o;
        int          cyc;
        bit          ok;
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        wait_done(ans, hl_o, cyc, ok);
        check({name, "_timeout"}, 64'(ok), 64'd1);
        check({name, "_ans"}, ans, exp_ans);
        check({name, "_hl"}, 64'(hl_o), 64'(exp_hl));
        check({name, "_busycyc"}, 64'(cyc), 64'd33);
        tick();
        check({name, "_idle"}, 64'(busy), 64'd0);
        check({name, "_hilo"}, hilo, exp_hilo);
    endtask

    vec_t vecs[8];

    initial begin
        logic [63:0] ans, prod, exp_hilo;
        logic        hl_o, exp_hl;
        int          cyc;
        bit          ok;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        vecs[0] = '{"multu_3x5",   2'b00, 32'd3,         32'd5,         64'h0000_0000_0000_000F};
        vecs[1] = '{"multu_max",   2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{"mult_m2x3",   2'b01, 32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA};
        vecs[3] = '{"mult_min2",   2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[4] = '{"mult_m1xm1",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        vecs[5] = '{"mult_minx1",  2'b01, 32'h8000_0000, 32'd1,         64'hFFFF_FFFF_8000_0000};
        vecs[6] = '{"multu_zero",  2'b00, 32'd0,         32'hDEAD_BEEF, 64'h0000_0000_0000_0000};
        vecs[7] = '{"mult_3xm5",   2'b01, 32'd3,         32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1};

        // Power-on reset
        #1 reset = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hl", 64'(HL), 64'd1);
        check("rst_ans", MultuAns, 64'd0);
        @(negedge clk); #2 reset = 1'b1;
        tick();

        foreach (vecs[i])
            do_mul(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ans, 1'b0, vecs[i].ans);

        // Reserved op is ignored
        start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd9;
        tick();
        start = 1'b0;
        check("rsvd_busy", 64'(busy), 64'd0);
        tick();
        check("rsvd_hilo", hilo, vecs[7].ans);

        // MADDU with HI/LO preloaded to 10
        preload_val = 64'd10; preload = 1'b1;
        @(negedge clk); #1 preload = 1'b0;
        tick();
        check("maddu_preload", hilo, 64'd10);
        do_mul("maddu", 2'b10, 32'd2, 32'd3, 64'd6, MADD_EN, MADD_EN ? 64'd16 : 64'd6);

        // Start together with MFHI in IDLE: accepted, no stall
        start = 1'b1; mfhl_req = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd21;
        #1;
        check("idle_req_stall", 64'(stall), 64'd0);
        tick();
        start = 1'b0; mfhl_req = 1'b0;
        check("idle_req_busy", 64'(busy), 64'd1);
        wait_done(ans, hl_o, cyc, ok);
        check("idle_req_ok", 64'(ok), 64'd1);
        check("idle_req_ans", ans, 64'd42);
        tick();

        // MFHI plus a second start raised at RUN cycle 5
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd5;
        tick();
        start = 1'b0;
        repeat (5) tick();
        mfhl_req = 1'b1; start = 1'b1; src_a = 32'd11; src_b = 32'd13;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            check("stall_held", 64'(stall), 64'd1);
            if (done) begin
                ok = 1'b1;
                check("stall_first_ans", MultuAns, 64'd15);
                break;
            end
            @(posedge clk); #0;
        end
        check("stall_first_ok", 64'(ok), 64'd1);
        tick();
        check("stall_drop", 64'(stall), 64'd0);
        check("stall_idle_busy", 64'(busy), 64'd0);
        check("stall_mfhi_value", hilo, 64'd15);
        tick();
        mfhl_req = 1'b0; start = 1'b0;
        check("second_accept", 64'(busy), 64'd1);
        wait_done(ans, hl_o, cyc, ok);
        check("second_ok", 64'(ok), 64'd1);
        check("second_ans", ans, 64'd143);
        tick();
        check("second_hilo", hilo, 64'd143);

        // Reset mid-RUN
        start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
        tick();
        start = 1'b0;
        repeat (10) tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hl", 64'(HL), 64'd1);
        check("midrst_ans", MultuAns, 64'd0);
        @(negedge clk); #2 reset = 1'b1;
        tick();
        check("midrst_idle", 64'(busy), 64'd0);
        check("midrst_hilo", hilo, 64'd143);
        do_mul("post_rst_7x7", 2'b00, 32'd7, 32'd7, 64'd49, 1'b0, 64'd49);

        // Randomized ops against the arithmetic model
        for (int n = 0; n < 16; n++) begin
            ro = 2'($urandom_range(0, 2));
            ra = $urandom;
            rb = $urandom;
            if (n == 0) ra = 32'h8000_0000;
            if (n == 1) rb = 32'hFFFF_FFFF;
            prod = model_prod(ro, ra, rb);
            exp_hl = MADD_EN && (ro == 2'b10);
            exp_hilo = exp_hl ? hilo + prod : prod;
            do_mul("rand", ro, ra, rb, prod, exp_hl, exp_hilo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hilo_mul_ctrl.md
# hilo_mul_ctrl

Multi-cycle multiply sequencer that owns the write side of the HI/LO register pair in the pipeline's EX stage. Accepts MULTU/MULT/MADDU from the decoder, runs a 32-iteration shift-add multiply, and drives the HI/LO register's 64-bit data input and load/accumulate select. Stalls the pipeline when MFHI/MFLO or a new multiply arrives while a multiply is in flight.

## Interface
- `MUL_CYCLES`, default 32: shift-add iterations; fixed to the operand width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; 0 = reset asserted.
- `start` in 1: multiply request; sampled only in IDLE.
- `op` in 2: 00 MULTU, 01 MULT (signed), 10 MADDU, 11 reserved (ignored, no accept).
- `src_a`, `src_b` in 32: operands, sampled on the accepting edge.
- `mfhl_req` in 1: the instruction in EX reads HI or LO.
- `busy` out 1: a multiply is in flight (RUN or WRITE).
- `stall` out 1: the pipeline must hold EX.
- `done` out 1: one-cycle pulse in WRITE.
- `MultuAns` out 64: data to the HI/LO register.
- `HL` out 1: 0 = HI/LO loads `MultuAns`; 1 = HI/LO adds `MultuAns`.

## Operation
- States: IDLE, RUN, WRITE.
- IDLE:
  - Outputs `HL`=1 and `MultuAns`=0, so HI/LO holds its value.
  - `start`=1 with `op`≠11 is accepted.
  - On accept, latch the operands and `op`, clear the counter, and go to RUN.
- RUN:
  - Product register P[63:0] is initialised to {32'b0, B}.
  - Each cycle: if P[0] is 1, P[63:31] ← {1'b0, P[63:32]} + A (33-bit add, carry kept), then shift P right by 1.
  - Go to WRITE after `MUL_CYCLES` iterations.
- MULT:
  - A = |src_a| and B = |src_b|, computed as unsigned 32-bit. The magnitude of −2^31 is 2^31.
  - sign = src_a[31] ^ src_b[31].
  - In WRITE, the result is the two's-complement negation of P when sign is 1.
- WRITE (exactly one cycle):
  - `MultuAns` = result.
  - `HL` = 0 for MULTU and MULT, 1 for MADDU.
  - `done` = 1.
  - Go to IDLE.
- `stall` = (`mfhl_req` | `start`) & (state ≠ IDLE).
  - A start during RUN or WRITE is not accepted; the held instruction is re-presented.
- `busy` = (state ≠ IDLE).
- Arithmetic:
  - Accumulation is modulo 2^64 and is performed by the HI/LO register.
  - The controller never reads HI/LO.
- Reset (any time, including mid-RUN):
  - State goes to IDLE, the counter and P are cleared.
  - Outputs: `busy`=0, `stall`=0, `done`=0, `HL`=1, `MultuAns`=0.
  - The partial product is discarded and HI/LO is not written.

## Timing
- Accept at rising edge E0. RUN occupies E0→E32 and WRITE occupies E32→E33. The controller is back in IDLE after E33.
- Latency from accept to HI/LO write is 33 cycles. Throughput is one multiply per 34 cycles; a start presented in the cycle after WRITE is accepted.
- HI/LO samples on the falling edge, so `MultuAns` and `HL` are stable for half a cycle before capture. The write lands on the falling edge inside the WRITE cycle.
- `stall` deasserts in the first IDLE cycle. MFHI/MFLO then reads the new value combinationally.
- `start` and `mfhl_req` together in IDLE: the multiply is accepted and `stall` stays 0 that cycle. The pipeline orders MFHI before the multiply, because that read completes first.

## Configuration
- `HILO_MADD_EN` defined: op 10 (MADDU) drives `HL`=1 in WRITE (accumulate).
- `HILO_MADD_EN` undefined: op 10 behaves exactly as MULTU (`HL`=0), and the accumulate path is not generated.

## Structure
- Package `hilo_pkg` holds:
  - op codes `OP_MULTU`, `OP_MULT`, `OP_MADDU`, `OP_RSVD`;
  - state enum `ST_IDLE`, `ST_RUN`, `ST_WRITE`;
  - constant `MUL_CYCLES` = 32.
- Sub-module `hilo_shift_mul` holds P, the 33-bit adder, shifting, and the final negation. It has load, step and negate controls.
- `hilo_mul_ctrl` holds the FSM, the 6-bit counter, `op`/sign latching, and the stall logic.

## Test plan
- MULTU, 3 × 5: `busy` is 1 for 33 cycles; WRITE shows `MultuAns`=0x0000_0000_0000_000F with `HL`=0; HI=0, LO=15.
- MULTU, 0xFFFF_FFFF × 0xFFFF_FFFF: result 0xFFFF_FFFE_0000_0001.
- MULT:
  - (−2) × 3 gives 0xFFFF_FFFF_FFFF_FFFA.
  - 0x8000_0000 × 0x8000_0000 gives 0x4000_0000_0000_0000.
- MADDU 2 × 3 after HI/LO = 10:
  - With `HILO_MADD_EN`: `HL`=1 and HI/LO = 16.
  - Without it: `HL`=0 and HI/LO = 6.
- `mfhl_req` and a second `start` raised at cycle 5 of RUN: `stall` stays 1 through WRITE and drops in the first IDLE cycle. The second multiply is accepted on the next edge.
- `reset`=0 pulsed mid-RUN (cycle 10): outputs return to their idle values immediately and HI/LO is unchanged. A new MULTU 7 × 7 then completes normally with 49.
